// File: rtl/axi_cache_bridge_pkg.sv
// Shared constants and FSM state types for the cache-to-AXI3 bridge.
package axi_cache_bridge_pkg;

  localparam logic [3:0] ID_INST    = 4'd0;
  localparam logic [3:0] ID_DATA    = 4'd1;
  localparam logic [2:0] SIZE_WORD  = 3'd2;
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [1:0] {RIdle, RAr, RData} rd_state_e;
  typedef enum logic [1:0] {WIdle, WAddr, WResp} wr_state_e;

endpackage

// File: rtl/axi_cache_bridge_if.sv
// Client-side request/response signals plus the AXI3 master pins of the bridge.
interface axi_cache_bridge_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              ic_req_valid, ic_req_ready;
   logic [ADDR_W-1:0] ic_req_addr;
   logic              ic_resp_valid, ic_resp_last;
   logic [31:0]       ic_resp_data;

   logic              dc_rd_req_valid, dc_rd_req_ready;
   logic [ADDR_W-1:0] dc_rd_req_addr;
   logic              dc_rd_resp_valid, dc_rd_resp_last;
   logic [31:0]       dc_rd_resp_data;

   logic              dc_wr_req_valid, dc_wr_req_ready;
   logic [ADDR_W-1:0] dc_wr_req_addr;
   logic [31:0]       dc_wr_req_data;
   logic [3:0]        dc_wr_req_strb;
   logic              dc_wr_done;

   logic [3:0]        arid;
   logic [ADDR_W-1:0] araddr;
   logic [3:0]        arlen;
   logic [2:0]        arsize;
   logic [1:0]        arburst;
   logic              arvalid, arready;
   logic [3:0]        rid;
   logic [31:0]       rdata;
   logic              rlast, rvalid, rready;

   logic [3:0]        awid, wid;
   logic [ADDR_W-1:0] awaddr;
   logic [3:0]        awlen;
   logic [2:0]        awsize;
   logic [1:0]        awburst;
   logic              awvalid, awready;
   logic [31:0]       wdata;
   logic [3:0]        wstrb;
   logic              wlast, wvalid, wready;
   logic              bvalid, bready;

   // rid is carried for completeness; the bridge routes by its registered owner instead.
   modport master (
      input  ic_req_valid, ic_req_addr, dc_rd_req_valid, dc_rd_req_addr,
             dc_wr_req_valid, dc_wr_req_addr, dc_wr_req_data, dc_wr_req_strb,
             arready, rdata, rlast, rvalid, awready, wready, bvalid,
      output ic_req_ready, ic_resp_valid, ic_resp_last, ic_resp_data,
             dc_rd_req_ready, dc_rd_resp_valid, dc_rd_resp_last, dc_rd_resp_data,
             dc_wr_req_ready, dc_wr_done,
             arid, araddr, arlen, arsize, arburst, arvalid, rready,
             awid, wid, awaddr, awlen, awsize, awburst, awvalid,
             wdata, wstrb, wlast, wvalid, bready
   );

   modport slave (
      output ic_req_valid, ic_req_addr, dc_rd_req_valid, dc_rd_req_addr,
             dc_wr_req_valid, dc_wr_req_addr, dc_wr_req_data, dc_wr_req_strb,
             arready, rid, rdata, rlast, rvalid, awready, wready, bvalid,
      input  ic_req_ready, ic_resp_valid, ic_resp_last, ic_resp_data,
             dc_rd_req_ready, dc_rd_resp_valid, dc_rd_resp_last, dc_rd_resp_data,
             dc_wr_req_ready, dc_wr_done,
             arid, araddr, arlen, arsize, arburst, arvalid, rready,
             awid, wid, awaddr, awlen, awsize, awburst, awvalid,
             wdata, wstrb, wlast, wvalid, bready
   );
endinterface

// File: rtl/axi_cache_bridge_write_channel.sv
// Single-beat store path: AW and W raised together, retired independently, then B.
module axi_write_channel
   import axi_cache_bridge_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [31:0]       req_data_i,
   input  logic [3:0]        req_strb_i,
   output logic              done_o,
   output logic              idle_o,
   output logic [ADDR_W-1:0] awaddr_o,
   output logic              awvalid_o,
   input  logic              awready_i,
   output logic [31:0]       wdata_o,
   output logic [3:0]        wstrb_o,
   output logic              wvalid_o,
   input  logic              wready_i,
   input  logic              bvalid_i,
   output logic              bready_o
);

   wr_state_e         state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       data_q, data_d;
   logic [3:0]        strb_q, strb_d;
   logic              aw_pend_q, aw_pend_d, w_pend_q, w_pend_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= WIdle;
         addr_q    <= '0;
         data_q    <= '0;
         strb_q    <= '0;
         aw_pend_q <= 1'b0;
         w_pend_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         strb_q    <= strb_d;
         aw_pend_q <= aw_pend_d;
         w_pend_q  <= w_pend_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      data_d      = data_q;
      strb_d      = strb_q;
      aw_pend_d   = aw_pend_q;
      w_pend_d    = w_pend_q;
      req_ready_o = 1'b0;
      awvalid_o   = 1'b0;
      wvalid_o    = 1'b0;
      bready_o    = 1'b0;
      done_o      = 1'b0;
      unique case (state_q)
         WIdle: begin
            req_ready_o = !rst_i;
            if (req_valid_i && !rst_i) begin
               addr_d    = req_addr_i;
               data_d    = req_data_i;
               strb_d    = req_strb_i;
               aw_pend_d = 1'b1;
               w_pend_d  = 1'b1;
               state_d   = WAddr;
            end
         end
         WAddr: begin
            awvalid_o = aw_pend_q;
            wvalid_o  = w_pend_q;
            if (awready_i) aw_pend_d = 1'b0;
            if (wready_i)  w_pend_d  = 1'b0;
            if (!aw_pend_d && !w_pend_d) state_d = WResp;
         end
         WResp: begin
            bready_o = 1'b1;
            if (bvalid_i) begin
               done_o  = 1'b1;
               state_d = WIdle;
            end
         end
         default: state_d = WIdle;
      endcase
   end

   assign idle_o   = (state_q == WIdle);
   assign awaddr_o = addr_q;
   assign wdata_o  = data_q;
   assign wstrb_o  = strb_q;

endmodule

// File: rtl/axi_cache_bridge.sv
// Merges icache/dcache line refills and dcache write-through stores onto one AXI3 master.
module axi_cache_bridge
   import axi_cache_bridge_pkg::*;
#(
   parameter int unsigned LINE_WORDS = 8,
   parameter int unsigned ADDR_W     = 32
) (
   input logic               clk_i,
   input logic               rst_i,
   axi_cache_bridge_if.master bus
);

   rd_state_e         state_q, state_d;
   logic              owner_dc_q, owner_dc_d;
   logic [ADDR_W-1:0] araddr_q, araddr_d;
   logic              wr_idle;
   logic              beat;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= RIdle;
         owner_dc_q <= 1'b0;
         araddr_q   <= '0;
      end else begin
         state_q    <= state_d;
         owner_dc_q <= owner_dc_d;
         araddr_q   <= araddr_d;
      end
   end

   // A dcache refill waits for the store path to drain so it cannot overtake a store.
   always_comb begin
      state_d             = state_q;
      owner_dc_d          = owner_dc_q;
      araddr_d            = araddr_q;
      bus.ic_req_ready    = 1'b0;
      bus.dc_rd_req_ready = 1'b0;
      bus.arvalid         = 1'b0;
      bus.rready          = 1'b0;
      unique case (state_q)
         RIdle: begin
            if (!rst_i) begin
               if (bus.dc_rd_req_valid && wr_idle) begin
                  bus.dc_rd_req_ready = 1'b1;
                  owner_dc_d          = 1'b1;
                  araddr_d            = bus.dc_rd_req_addr;
                  state_d             = RAr;
               end else if (bus.ic_req_valid) begin
                  bus.ic_req_ready = 1'b1;
                  owner_dc_d       = 1'b0;
                  araddr_d         = bus.ic_req_addr;
                  state_d          = RAr;
               end
            end
         end
         RAr: begin
            bus.arvalid = 1'b1;
            if (bus.arready) state_d = RData;
         end
         RData: begin
            bus.rready = 1'b1;
            if (bus.rvalid && bus.rlast) state_d = RIdle;
         end
         default: state_d = RIdle;
      endcase
   end

   assign bus.arid    = owner_dc_q ? ID_DATA : ID_INST;
   assign bus.araddr  = araddr_q;
   assign bus.arlen   = 4'(LINE_WORDS - 1);
   assign bus.arsize  = SIZE_WORD;
   assign bus.arburst = BURST_INCR;

   assign beat                 = (state_q == RData) && bus.rvalid;
   assign bus.ic_resp_valid    = beat && !owner_dc_q;
   assign bus.ic_resp_last     = beat && !owner_dc_q && bus.rlast;
   assign bus.ic_resp_data     = bus.rdata;
   assign bus.dc_rd_resp_valid = beat && owner_dc_q;
   assign bus.dc_rd_resp_last  = beat && owner_dc_q && bus.rlast;
   assign bus.dc_rd_resp_data  = bus.rdata;

   assign bus.awid    = ID_DATA;
   assign bus.wid     = ID_DATA;
   assign bus.awlen   = 4'd0;
   assign bus.awsize  = SIZE_WORD;
   assign bus.awburst = BURST_INCR;
   assign bus.wlast   = 1'b1;

   axi_write_channel #(
      .ADDR_W (ADDR_W)
   ) u_write (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_valid_i (bus.dc_wr_req_valid),
      .req_ready_o (bus.dc_wr_req_ready),
      .req_addr_i  (bus.dc_wr_req_addr),
      .req_data_i  (bus.dc_wr_req_data),
      .req_strb_i  (bus.dc_wr_req_strb),
      .done_o      (bus.dc_wr_done),
      .idle_o      (wr_idle),
      .awaddr_o    (bus.awaddr),
      .awvalid_o   (bus.awvalid),
      .awready_i   (bus.awready),
      .wdata_o     (bus.wdata),
      .wstrb_o     (bus.wstrb),
      .wvalid_o    (bus.wvalid),
      .wready_i    (bus.wready),
      .bvalid_i    (bus.bvalid),
      .bready_o    (bus.bready)
   );

endmodule

// File: tb/tb_axi_cache_bridge.sv
// Directed bench for axi_cache_bridge: table-driven refills plus multi-cycle corner sequences.
module tb_axi_cache_bridge;

   localparam int unsigned LW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   axi_cache_bridge_if #(.ADDR_W(32)) bus ();

   axi_cache_bridge #(
      .LINE_WORDS (LW),
      .ADDR_W     (32)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   typedef struct {
      bit          dc;
      logic [31:0] addr;
      logic [31:0] base;
      int          ar_delay;
      logic [3:0]  exp_arid;
   } rd_vec_t;

   rd_vec_t vecs [4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [9:0] outs();
      return {bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready, bus.ic_req_ready,
              bus.dc_rd_req_ready, bus.ic_resp_valid, bus.dc_rd_resp_valid, bus.dc_wr_done};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Entered one cycle after the grant; leaves with the read FSM in its data phase.
   task automatic ar_phase(input logic [3:0] arid, input logic [31:0] addr, input int delay);
      #1;
      chk("arvalid", 32'(bus.arvalid), 1);
      chk("araddr", bus.araddr, addr);
      chk("arid", 32'(bus.arid), 32'(arid));
      chk("arlen_size_burst", {23'd0, bus.arlen, bus.arsize, bus.arburst}, {23'd0, 4'd7, 3'd2, 2'b01});
      for (int i = 0; i < delay; i++) begin
         step();
         chk("ar_hold_valid", 32'(bus.arvalid), 1);
         chk("ar_hold_addr", bus.araddr, addr);
         chk("ar_hold_noresp", {30'd0, bus.ic_resp_valid, bus.dc_rd_resp_valid}, 0);
      end
      bus.arready = 1'b1;
      step();
      bus.arready = 1'b0;
   endtask

   task automatic data_phase(input bit dc, input logic [31:0] base, input int n, input int last_idx);
      for (int i = 0; i < n; i++) begin
         bus.rvalid = 1'b1;
         bus.rdata  = base + 32'(i);
         bus.rlast  = (i == last_idx);
         bus.rid    = dc ? 4'd1 : 4'd0;
         #1;
         chk("rready", 32'(bus.rready), 1);
         chk("resp_valid", {30'd0, bus.ic_resp_valid, bus.dc_rd_resp_valid},
             dc ? 32'd1 : 32'd2);
         chk("resp_data", dc ? bus.dc_rd_resp_data : bus.ic_resp_data, base + 32'(i));
         chk("resp_last", {30'd0, bus.ic_resp_last, bus.dc_rd_resp_last},
             (i == last_idx) ? (dc ? 32'd1 : 32'd2) : 32'd0);
         step();
      end
      bus.rvalid = 1'b0;
      bus.rlast  = 1'b0;
   endtask

   task automatic do_read(input rd_vec_t v);
      if (v.dc) begin
         bus.dc_rd_req_valid = 1'b1;
         bus.dc_rd_req_addr  = v.addr;
      end else begin
         bus.ic_req_valid = 1'b1;
         bus.ic_req_addr  = v.addr;
      end
      #1;
      chk("grant_ready", {30'd0, bus.ic_req_ready, bus.dc_rd_req_ready}, v.dc ? 32'd1 : 32'd2);
      step();
      bus.dc_rd_req_valid = 1'b0;
      bus.ic_req_valid    = 1'b0;
      ar_phase(v.exp_arid, v.addr, v.ar_delay);
      data_phase(v.dc, v.base, LW, LW - 1);
   endtask

   // Beats counted from the first W_ADDR cycle; awready/wready pulse at the given offsets.
   task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_lat, input int w_lat);
      int last;
      last = (aw_lat > w_lat) ? aw_lat : w_lat;
      bus.dc_wr_req_valid = 1'b1;
      bus.dc_wr_req_addr  = addr;
      bus.dc_wr_req_data  = data;
      bus.dc_wr_req_strb  = strb;
      #1;
      chk("wr_req_ready", 32'(bus.dc_wr_req_ready), 1);
      step();
      bus.dc_wr_req_valid = 1'b0;
      #1;
      chk("aw_fields", bus.awaddr, addr);
      chk("w_fields", {bus.wdata}, data);
      chk("w_strb_last_len", {23'd0, bus.wstrb, bus.wlast, bus.awlen},
          {23'd0, strb, 1'b1, 4'd0});
      chk("aw_w_ids", {24'd0, bus.awid, bus.wid}, 32'h11);
      for (int c = 0; c <= last; c++) begin
         bus.awready = (c == aw_lat);
         bus.wready  = (c == w_lat);
         #1;
         chk("awvalid_track", 32'(bus.awvalid), 32'(c <= aw_lat));
         chk("wvalid_track", 32'(bus.wvalid), 32'(c <= w_lat));
         step();
      end
      bus.awready = 1'b0;
      bus.wready  = 1'b0;
      #1;
      chk("b_wait", {29'd0, bus.awvalid, bus.wvalid, bus.bready, bus.dc_wr_done}, 32'd2);
      step();
      bus.bvalid = 1'b1;
      #1;
      chk("wr_done_pulse", 32'(bus.dc_wr_done), 1);
      step();
      bus.bvalid = 1'b0;
      #1;
      chk("wr_done_clear", {30'd0, bus.dc_wr_done, bus.dc_wr_req_ready}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{dc: 1'b0, addr: 32'h1FC0_0000, base: 32'h0,         ar_delay: 0, exp_arid: 4'd0};
      vecs[1] = '{dc: 1'b1, addr: 32'h8000_1000, base: 32'h100,       ar_delay: 1, exp_arid: 4'd1};
      vecs[2] = '{dc: 1'b0, addr: 32'h0000_0040, base: 32'hA5A5_0000, ar_delay: 0, exp_arid: 4'd0};
      vecs[3] = '{dc: 1'b1, addr: 32'hFFFF_FFE0, base: 32'hFFFF_FFF8, ar_delay: 5, exp_arid: 4'd1};

      bus.ic_req_valid = 0; bus.ic_req_addr = 0;
      bus.dc_rd_req_valid = 0; bus.dc_rd_req_addr = 0;
      bus.dc_wr_req_valid = 0; bus.dc_wr_req_addr = 0;
      bus.dc_wr_req_data = 0; bus.dc_wr_req_strb = 0;
      bus.arready = 0; bus.rid = 0; bus.rdata = 0; bus.rlast = 0; bus.rvalid = 0;
      bus.awready = 0; bus.wready = 0; bus.bvalid = 0;

      #1;
      chk("reset_outs", 32'(outs()), 0);
      chk("reset_wr_ready", 32'(bus.dc_wr_req_ready), 0);
      step();
      step();
      rst = 1'b0;
      #1;
      chk("post_reset_wr_ready", 32'(bus.dc_wr_req_ready), 1);
      step();

      for (int i = 0; i < 4; i++) do_read(vecs[i]);

      // Simultaneous ic/dc refill: dc first, ic granted right after dc's rlast.
      bus.ic_req_valid    = 1'b1;
      bus.ic_req_addr     = 32'h0000_2000;
      bus.dc_rd_req_valid = 1'b1;
      bus.dc_rd_req_addr  = 32'h9000_0020;
      #1;
      chk("both_req_grant", {30'd0, bus.ic_req_ready, bus.dc_rd_req_ready}, 32'd1);
      step();
      bus.dc_rd_req_valid = 1'b0;
      chk("ic_wait_ar", 32'(bus.ic_req_ready), 0);
      ar_phase(4'd1, 32'h9000_0020, 0);
      data_phase(1'b1, 32'h300, LW - 1, 99);
      chk("ic_wait_data", 32'(bus.ic_req_ready), 0);
      data_phase(1'b1, 32'h300 + 32'(LW - 1), 1, 0);
      #1;
      chk("ic_after_dc", 32'(bus.ic_req_ready), 1);
      step();
      bus.ic_req_valid = 1'b0;
      ar_phase(4'd0, 32'h0000_2000, 0);
      data_phase(1'b0, 32'h400, 2, 1);

      do_store(32'h8000_0010, 32'hDEAD_BEEF, 4'b0011, 0, 3);
      do_store(32'h8000_0020, 32'h1234_5678, 4'b1100, 2, 0);
      do_store(32'h8000_0030, 32'hCAFE_F00D, 4'b1111, 1, 1);

      // Store parked in W_RESP: dc refill held off, ic refill proceeds.
      bus.dc_wr_req_valid = 1'b1;
      bus.dc_wr_req_addr  = 32'h8000_0040;
      bus.dc_wr_req_data  = 32'h0BAD_F00D;
      bus.dc_wr_req_strb  = 4'hF;
      step();
      bus.dc_wr_req_valid = 1'b0;
      bus.awready = 1'b1;
      bus.wready  = 1'b1;
      step();
      bus.awready = 1'b0;
      bus.wready  = 1'b0;
      bus.dc_rd_req_valid = 1'b1;
      bus.dc_rd_req_addr  = 32'hA000_0000;
      bus.ic_req_valid    = 1'b1;
      bus.ic_req_addr     = 32'h0000_3000;
      #1;
      chk("wresp_grant", {30'd0, bus.ic_req_ready, bus.dc_rd_req_ready}, 32'd2);
      step();
      bus.ic_req_valid = 1'b0;
      ar_phase(4'd0, 32'h0000_3000, 0);
      data_phase(1'b0, 32'h500, 3, 2);
      #1;
      chk("dc_blocked_wresp", {30'd0, bus.dc_rd_req_ready, bus.bready}, 32'd1);
      bus.bvalid = 1'b1;
      #1;
      chk("wresp_done", {30'd0, bus.dc_wr_done, bus.dc_rd_req_ready}, 32'd2);
      step();
      bus.bvalid = 1'b0;
      #1;
      chk("dc_after_wresp", 32'(bus.dc_rd_req_ready), 1);
      step();
      bus.dc_rd_req_valid = 1'b0;
      ar_phase(4'd1, 32'hA000_0000, 0);
      data_phase(1'b1, 32'h600, LW, LW - 1);

      // Reset during beat 3 abandons the burst.
      bus.ic_req_valid = 1'b1;
      bus.ic_req_addr  = 32'h0000_4000;
      step();
      bus.ic_req_valid = 1'b0;
      ar_phase(4'd0, 32'h0000_4000, 0);
      data_phase(1'b0, 32'h700, 3, 99);
      bus.rvalid = 1'b1;
      bus.rdata  = 32'h703;
      #1;
      chk("beat3_present", 32'(bus.ic_resp_valid), 1);
      rst = 1'b1;
      #1;
      chk("reset_midburst", 32'(outs()), 0);
      step();
      step();
      rst = 1'b0;
      bus.rvalid = 1'b0;
      #1;
      chk("after_reset_idle", {21'd0, outs(), bus.dc_wr_req_ready}, 32'd1);
      step();
      do_read('{dc: 1'b0, addr: 32'h0000_4000, base: 32'h800, ar_delay: 0, exp_arid: 4'd0});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
